csr_encoder: RTL and testbench

- Streaming dense-to-CSR encoder: accepts a dense N x M int matrix in row-major order via valid/ready and emits the CSR arrays (val, col, rowPtr) as write strobes into the SpMV operand memories.
- Produces exactly the val/col/rowPtr images that the row-multiplication datapath consumes: the writer end of the CSR interface.
- Sits between the matrix loader and the operand RAMs; one matrix per start pulse.

---
 rtl/csr_encoder.sv | 158 +++++++++++++++
 tb/tb_csr_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_encoder.sv
// rtl/csr_encoder.sv - streaming dense-to-CSR encoder writing val/col/rowPtr memories
module csr_encoder #(
   parameter int N       = 4,
   parameter int M       = 4,
   parameter int NNZ_MAX = 16,
   parameter int W       = 32,
   localparam int AW     = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1,
   localparam int CLW    = (M > 1) ? $clog2(M) : 1,
   localparam int RPW    = $clog2(N + 1),
   localparam int CW     = $clog2(NNZ_MAX + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic signed [W-1:0] in_data,
   output logic                in_ready,
   output logic                val_we,
   output logic [AW-1:0]       val_addr,
   output logic [W-1:0]        val_data,
   output logic [CLW-1:0]      col_data,
   output logic                rp_we,
   output logic [RPW-1:0]      rp_addr,
   output logic [CW-1:0]       rp_data,
   output logic [CW-1:0]       nnz_count,
   output logic                overflow,
   output logic                done
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;

   localparam logic [CW-1:0]  NNZ_FULL = CW'(NNZ_MAX);
   localparam logic [CLW-1:0] COL_LAST = CLW'(M - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(N - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_val_we;
   logic [AW-1:0]    r_val_addr;
   logic [W-1:0]     r_val_data;
   logic [CLW-1:0]   r_col_data;
   logic             r_rp_we;
   logic [RPW-1:0]   r_rp_addr;
   logic [CW-1:0]    r_rp_data;
   logic [CW-1:0]    r_nnz;
   logic             r_overflow;
   logic [RW-1:0]    r_row;
   logic [CLW-1:0]   r_col;

   logic             w_start_ok;
   logic             w_xfer;
   logic             w_nonzero;
   logic             w_store;
   logic             w_row_end;
   logic             w_last;
   logic [CW-1:0]    w_nnz_next;

   assign w_start_ok = start && (r_state != S_RUN);
   assign w_xfer     = in_valid && in_ready;
   assign w_nonzero  = (in_data != '0);
   assign w_store    = w_xfer && w_nonzero && (r_nnz < NNZ_FULL);
   assign w_row_end  = (r_col == COL_LAST);
   assign w_last     = w_row_end && (r_row == ROW_LAST);
   assign w_nnz_next = w_store ? (r_nnz + CW'(1)) : r_nnz;

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state: start only honoured outside RUN; last transfer ends the matrix
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
         S_RUN:   if (w_xfer && w_last) w_state_nxt = S_DONE;
         S_DONE:  if (w_start_ok) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_RUN:   in_ready = 1'b1;
         S_DONE:  done     = 1'b1;
         default: ;
      endcase
   end

   // datapath: registered write strobes, counters and sticky overflow
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_val_we   <= 1'b0;
         r_val_addr <= '0;
         r_val_data <= '0;
         r_col_data <= '0;
         r_rp_we    <= 1'b0;
         r_rp_addr  <= '0;
         r_rp_data  <= '0;
         r_nnz      <= '0;
         r_overflow <= 1'b0;
         r_row      <= '0;
         r_col      <= '0;
      end else begin
         r_val_we <= 1'b0;
         r_rp_we  <= 1'b0;
         if (w_start_ok) begin
            r_rp_we    <= 1'b1;
            r_rp_addr  <= '0;
            r_rp_data  <= '0;
            r_nnz      <= '0;
            r_overflow <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
         end else if (w_xfer) begin
            if (w_store) begin
               r_val_we   <= 1'b1;
               r_val_addr <= r_nnz[AW-1:0];
               r_val_data <= in_data;
               r_col_data <= r_col;
            end else if (w_nonzero) begin
               r_overflow <= 1'b1;
            end
            r_nnz <= w_nnz_next;
            if (w_row_end) begin
               r_rp_we   <= 1'b1;
               r_rp_addr <= RPW'(r_row) + RPW'(1);
               r_rp_data <= w_nnz_next;
               r_col     <= '0;
               r_row     <= r_row + RW'(1);
            end else begin
               r_col <= r_col + CLW'(1);
            end
         end
      end
   end

   assign val_we    = r_val_we;
   assign val_addr  = r_val_addr;
   assign val_data  = r_val_data;
   assign col_data  = r_col_data;
   assign rp_we     = r_rp_we;
   assign rp_addr   = r_rp_addr;
   assign rp_data   = r_rp_data;
   assign nnz_count = r_nnz;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_csr_encoder.sv
// tb/tb_csr_encoder.sv - randomized self-checking bench for csr_encoder
module tb_csr_encoder;

   localparam int TN   = 4;
   localparam int TM   = 4;
   localparam int TNNZ = 6;
   localparam int TW   = 32;
   localparam int NE   = TN * TM;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [TW-1:0] in_data = '0;
   logic                 in_ready;
   logic                 val_we;
   logic [2:0]           val_addr;
   logic [TW-1:0]        val_data;
   logic [1:0]           col_data;
   logic                 rp_we;
   logic [2:0]           rp_addr;
   logic [2:0]           rp_data;
   logic [2:0]           nnz_count;
   logic                 overflow;
   logic                 done;

   csr_encoder #(.N(TN), .M(TM), .NNZ_MAX(TNNZ), .W(TW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .val_we(val_we), .val_addr(val_addr), .val_data(val_data),
      .col_data(col_data), .rp_we(rp_we), .rp_addr(rp_addr), .rp_data(rp_data),
      .nnz_count(nnz_count), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   int mat[NE];
   int acc_q[$];
   int wv_cyc[$], wv_addr[$], wv_data[$], wv_col[$];
   int wr_addr[$], wr_data[$];

   // write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (val_we) begin
         wv_cyc.push_back(cyc);
         wv_addr.push_back(int'(val_addr));
         wv_data.push_back(int'(val_data));
         wv_col.push_back(int'(col_data));
      end
      if (rp_we) begin
         wr_addr.push_back(int'(rp_addr));
         wr_data.push_back(int'(rp_data));
      end
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      acc_q.delete();
      wv_cyc.delete(); wv_addr.delete(); wv_data.delete(); wv_col.delete();
      wr_addr.delete(); wr_data.delete();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check_eq("start_rp_we", rp_we, 1);
      check_eq("start_rp_addr", rp_addr, 0);
      check_eq("start_rp_data", rp_data, 0);
      check_eq("start_done", done, 0);
      check_eq("start_nnz", nnz_count, 0);
      check_eq("start_ovf", overflow, 0);
      check_eq("start_ready", in_ready, 1);
   endtask

   // feed the first n elements; optional bubbles and a start pulse at element start_at
   task automatic send_matrix(input int n, input bit bubbles, input int start_at);
      int gap;
      bit ok;
      ok = 1'b1;
      for (int idx = 0; idx < n && ok; idx++) begin
         gap = 0;
         forever begin
            @(posedge clk); #1;
            in_valid = (bubbles && gap < 3 && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            in_data  = mat[idx];
            start    = (idx == start_at);
            @(negedge clk);
            if (in_valid && in_ready) begin
               acc_q.push_back(cyc + 1);
               break;
            end
            gap++;
            if (gap > 20) begin
               check_eq("xfer_timeout", 0, 1);
               ok = 1'b0;
               break;
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
      if (n == NE) begin
         @(negedge clk);
         check_eq("done_after_last", done, 1);
         check_eq("ready_after_last", in_ready, 0);
      end
   endtask

   // reference: CSR image computed directly from the dense matrix
   task automatic verify(input string name);
      int ev[$], ec[$], ecyc[$];
      int total, kept, nz_before;
      @(posedge clk); @(negedge clk);
      total = 0;
      for (int i = 0; i < NE; i++) begin
         if (mat[i] != 0) begin
            total++;
            if (ev.size() < TNNZ) begin
               ev.push_back(mat[i]);
               ec.push_back(i % TM);
               ecyc.push_back(acc_q[i]);
            end
         end
      end
      kept = ev.size();
      check_eq({name, "_nval"}, wv_cyc.size(), kept);
      for (int k = 0; k < kept && k < wv_cyc.size(); k++) begin
         check_eq({name, "_vaddr"}, wv_addr[k], k);
         check_eq({name, "_vdata"}, wv_data[k], ev[k]);
         check_eq({name, "_vcol"}, wv_col[k], ec[k]);
         check_eq({name, "_vcyc"}, wv_cyc[k], ecyc[k]);
      end
      check_eq({name, "_nrp"}, wr_addr.size(), TN + 1);
      for (int r = 0; r <= TN && r < wr_addr.size(); r++) begin
         nz_before = 0;
         for (int i = 0; i < r * TM; i++) if (mat[i] != 0) nz_before++;
         check_eq({name, "_rpaddr"}, wr_addr[r], r);
         check_eq({name, "_rpdata"}, wr_data[r], (nz_before < TNNZ) ? nz_before : TNNZ);
      end
      check_eq({name, "_nnz"}, nnz_count, kept);
      check_eq({name, "_ovf"}, overflow, (total > TNNZ) ? 1 : 0);
      check_eq({name, "_done"}, done, 1);
      check_eq({name, "_ready"}, in_ready, 0);
   endtask

   task automatic encode(input string name, input bit bubbles, input int start_at);
      clear_mon();
      pulse_start();
      send_matrix(NE, bubbles, start_at);
      verify(name);
   endtask

   task automatic check_reset_state(input string name);
      check_eq({name, "_ready"}, in_ready, 0);
      check_eq({name, "_done"}, done, 0);
      check_eq({name, "_ovf"}, overflow, 0);
      check_eq({name, "_nnz"}, nnz_count, 0);
      check_eq({name, "_vwe"}, val_we, 0);
      check_eq({name, "_rpwe"}, rp_we, 0);
      check_eq({name, "_vaddr"}, val_addr, 0);
      check_eq({name, "_rpaddr"}, rp_addr, 0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check_reset_state("reset");
      #1 rst = 1'b1;
   endtask

   task automatic rand_matrix(input int zero_pct);
      for (int i = 0; i < NE; i++) begin
         if ($urandom_range(0, 99) < zero_pct) mat[i] = 0;
         else begin
            mat[i] = int'($urandom);
            if (mat[i] == 0) mat[i] = -1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();

      // sparse example with a negative entry
      foreach (mat[i]) mat[i] = 0;
      mat[0] = 5; mat[6] = -2; mat[8] = 7; mat[9] = 8;
      encode("example", 1'b0, -1);
      encode("example_bub", 1'b1, -1);

      foreach (mat[i]) mat[i] = 0;
      encode("zeros", 1'b0, -1);

      foreach (mat[i]) mat[i] = 1;
      encode("ones_ovf", 1'b0, -1);
      apply_reset();

      // reset after 5 transfers, then clean re-encode
      clear_mon();
      pulse_start();
      send_matrix(5, 1'b0, -1);
      apply_reset();
      rand_matrix(50);
      encode("after_rst", 1'b0, -1);

      // start pulsed mid-RUN must be ignored
      rand_matrix(60);
      encode("start_midrun", 1'b1, 7);

      for (int t = 0; t < 12; t++) begin
         rand_matrix($urandom_range(0, 100));
         encode("rand", t[0], -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
